// File: rtl/load_store_unit_pkg.sv
// Shared processor defines: LSU state encodings and access size codes.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_t;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

endpackage

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit between the core and an 8-bit data memory.
// Halfword accesses take two memory cycles (little-endian, address wraps).
//
// state | meaning
// IDLE  | waiting for lsu_req_i
// BYTE0 | memory access to captured address
// BYTE1 | memory access to captured address + 1 (halfword only)
// DONE  | one-cycle completion pulse, load result valid
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic                  lsu_size_i,
    input  logic [ADDR_W-1:0]     lsu_addr_i,
    input  logic [2*DATA_W-1:0]   lsu_wr_data_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_done_o,
    output logic [2*DATA_W-1:0]   lsu_rd_data_o,
    output logic                  data_mem_rd_enb_o,
    output logic                  data_mem_wr_enb_o,
    output logic [ADDR_W-1:0]     data_mem_addr_o,
    output logic [DATA_W-1:0]     data_mem_wr_data_o,
    input  logic [DATA_W-1:0]     data_mem_rd_data_i
);

    lsu_state_t            r_state;
    logic                  r_we;
    logic                  r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [2*DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]     r_lo;
    logic [ADDR_W-1:0]     w_addr_next;

    assign w_addr_next = r_addr + ADDR_W'(1);

    // Memory-side outputs are registered and set up for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= ST_IDLE;
            r_we               <= 1'b0;
            r_size             <= SZ_BYTE;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_lo               <= '0;
            lsu_busy_o         <= 1'b0;
            lsu_done_o         <= 1'b0;
            lsu_rd_data_o      <= '0;
            data_mem_rd_enb_o  <= 1'b0;
            data_mem_wr_enb_o  <= 1'b0;
            data_mem_addr_o    <= '0;
            data_mem_wr_data_o <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    lsu_done_o <= 1'b0;
                    if (lsu_req_i) begin
                        r_state            <= ST_BYTE0;
                        r_we               <= lsu_we_i;
                        r_size             <= lsu_size_i;
                        r_addr             <= lsu_addr_i;
                        r_wdata            <= lsu_wr_data_i;
                        lsu_busy_o         <= 1'b1;
                        data_mem_addr_o    <= lsu_addr_i;
                        data_mem_rd_enb_o  <= ~lsu_we_i;
                        data_mem_wr_enb_o  <= lsu_we_i;
                        data_mem_wr_data_o <= lsu_we_i ? lsu_wr_data_i[DATA_W-1:0] : '0;
                    end
                end
                ST_BYTE0: begin
                    if (!r_we) begin
                        r_lo <= data_mem_rd_data_i;
                    end
                    if (r_size == SZ_HALF) begin
                        r_state            <= ST_BYTE1;
                        data_mem_addr_o    <= w_addr_next;
                        data_mem_wr_data_o <= r_we ? r_wdata[2*DATA_W-1:DATA_W] : '0;
                    end else begin
                        r_state            <= ST_DONE;
                        lsu_done_o         <= 1'b1;
                        data_mem_rd_enb_o  <= 1'b0;
                        data_mem_wr_enb_o  <= 1'b0;
                        data_mem_addr_o    <= '0;
                        data_mem_wr_data_o <= '0;
                        if (!r_we) begin
                            lsu_rd_data_o <= {{DATA_W{1'b0}}, data_mem_rd_data_i};
                        end
                    end
                end
                ST_BYTE1: begin
                    r_state            <= ST_DONE;
                    lsu_done_o         <= 1'b1;
                    data_mem_rd_enb_o  <= 1'b0;
                    data_mem_wr_enb_o  <= 1'b0;
                    data_mem_addr_o    <= '0;
                    data_mem_wr_data_o <= '0;
                    if (!r_we) begin
                        lsu_rd_data_o <= {data_mem_rd_data_i, r_lo};
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    lsu_busy_o <= 1'b0;
                    lsu_done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-wide memory model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic        lsu_size_i = 1'b0;
    logic [7:0]  lsu_addr_i = 8'h00;
    logic [15:0] lsu_wr_data_i = 16'h0000;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [15:0] lsu_rd_data_o;
    logic        data_mem_rd_enb_o;
    logic        data_mem_wr_enb_o;
    logic [7:0]  data_mem_addr_o;
    logic [7:0]  data_mem_wr_data_o;
    logic [7:0]  data_mem_rd_data_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_wr = 0;

    load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_req_i          (lsu_req_i),
        .lsu_we_i           (lsu_we_i),
        .lsu_size_i         (lsu_size_i),
        .lsu_addr_i         (lsu_addr_i),
        .lsu_wr_data_i      (lsu_wr_data_i),
        .lsu_busy_o         (lsu_busy_o),
        .lsu_done_o         (lsu_done_o),
        .lsu_rd_data_o      (lsu_rd_data_o),
        .data_mem_rd_enb_o  (data_mem_rd_enb_o),
        .data_mem_wr_enb_o  (data_mem_wr_enb_o),
        .data_mem_addr_o    (data_mem_addr_o),
        .data_mem_wr_data_o (data_mem_wr_data_o),
        .data_mem_rd_data_i (data_mem_rd_data_i)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational read.
    logic [7:0] mem [256];
    initial foreach (mem[i]) mem[i] = 8'h00;
    always @(posedge clk) if (data_mem_wr_enb_o) mem[data_mem_addr_o] <= data_mem_wr_data_o;
    assign data_mem_rd_data_i = data_mem_rd_enb_o ? mem[data_mem_addr_o] : 8'h00;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (lsu_done_o) n_done++;
        if (data_mem_wr_enb_o) n_wr++;
    end

    // Reference model: a transaction occupies len byte cycles then one done cycle.
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic        m_we = 1'b0;
    logic        m_size = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wdata = 16'h0000;
    logic [15:0] m_exp_rd = 16'h0000;
    logic [7:0]  ref_mem [256];
    initial foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    always @(posedge clk or negedge rst) begin
        int len;
        if (!rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_exp_rd = 16'h0000;
        end else if (!m_active) begin
            if (lsu_req_i) begin
                m_active = 1'b1;
                m_k      = 1;
                m_we     = lsu_we_i;
                m_size   = lsu_size_i;
                m_addr   = lsu_addr_i;
                m_wdata  = lsu_wr_data_i;
            end
        end else begin
            len = m_size ? 2 : 1;
            if (m_k == len) begin
                if (m_we) begin
                    ref_mem[m_addr] = m_wdata[7:0];
                    if (m_size) ref_mem[8'(m_addr + 8'd1)] = m_wdata[15:8];
                end else begin
                    m_exp_rd = {m_size ? ref_mem[8'(m_addr + 8'd1)] : 8'h00, ref_mem[m_addr]};
                end
            end
            if (m_k == len + 1) m_active = 1'b0;
            else m_k++;
        end
    end

    always @(negedge clk) begin
        logic [43:0] exp_v, act_v;
        logic        e_rd, e_wr, e_done;
        logic [7:0]  e_addr, e_wd;
        int          len;
        len    = m_size ? 2 : 1;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_addr = 8'h00;
        e_wd   = 8'h00;
        e_done = m_active && (m_k == len + 1);
        if (m_active && m_k <= len) begin
            e_rd   = !m_we;
            e_wr   = m_we;
            e_addr = 8'(m_addr + 8'(m_k - 1));
            e_wd   = m_we ? ((m_k == 1) ? m_wdata[7:0] : m_wdata[15:8]) : 8'h00;
        end
        exp_v = {m_active, e_done, m_exp_rd, e_rd, e_wr, e_addr, e_wd, 2'b00};
        act_v = {lsu_busy_o, lsu_done_o, lsu_rd_data_o, data_mem_rd_enb_o,
                 data_mem_wr_enb_o, data_mem_addr_o, data_mem_wr_data_o, 2'b00};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_model t=%0t busy/done/rd/rde/wre/addr/wd got %b %b %h %b %b %h %h want %b %b %h %b %b %h %h",
                     $time, lsu_busy_o, lsu_done_o, lsu_rd_data_o, data_mem_rd_enb_o,
                     data_mem_wr_enb_o, data_mem_addr_o, data_mem_wr_data_o,
                     m_active, e_done, m_exp_rd, e_rd, e_wr, e_addr, e_wd);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic size, input logic [7:0] addr,
                          input logic [15:0] wd, output int lat);
        int c0;
        int n;
        @(negedge clk);
        lsu_req_i     = 1'b1;
        lsu_we_i      = we;
        lsu_size_i    = size;
        lsu_addr_i    = addr;
        lsu_wr_data_i = wd;
        c0 = cyc;
        @(negedge clk);
        lsu_req_i = 1'b0;
        n = 0;
        while (!lsu_done_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!lsu_done_o) begin
            total++;
            bad++;
            $display("FAIL done_timeout addr=%h got no done want done", addr);
            lat = -1;
        end else begin
            lat = cyc - c0;
        end
        @(negedge clk);
    endtask

    initial begin
        int lat, w0, d0, nb, nrd, nd, guard;
        #12;
        check("reset_busy", 16'(lsu_busy_o), 16'h0);
        check("reset_done", 16'(lsu_done_o), 16'h0);
        check("reset_rd_data", lsu_rd_data_o, 16'h0000);
        check("reset_mem_if", {6'h0, data_mem_rd_enb_o, data_mem_wr_enb_o, data_mem_addr_o}, 16'h0000);
        rst = 1'b1;

        w0 = n_wr;
        do_req(1'b1, 1'b0, 8'h10, 16'hAB5A, lat);
        check("bstore_latency", 16'(lat), 16'd2);
        check("bstore_wr_cycles", 16'(n_wr - w0), 16'd1);
        check("bstore_mem10", 16'(mem[8'h10]), 16'h005A);
        check("bstore_mem11", 16'(mem[8'h11]), 16'h0000);
        check("bstore_rd_unchanged", lsu_rd_data_o, 16'h0000);

        do_req(1'b1, 1'b1, 8'h20, 16'h1234, lat);
        check("hstore_latency", 16'(lat), 16'd3);
        check("hstore_mem20", 16'(mem[8'h20]), 16'h0034);
        check("hstore_mem21", 16'(mem[8'h21]), 16'h0012);
        do_req(1'b0, 1'b1, 8'h20, 16'h0000, lat);
        check("hload_latency", 16'(lat), 16'd3);
        check("hload_20", lsu_rd_data_o, 16'h1234);

        do_req(1'b1, 1'b1, 8'hFF, 16'hBEEF, lat);
        check("wrap_memFF", 16'(mem[8'hFF]), 16'h00EF);
        check("wrap_mem00", 16'(mem[8'h00]), 16'h00BE);
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, lat);
        check("wrap_load", lsu_rd_data_o, 16'hBEEF);

        do_req(1'b0, 1'b0, 8'h21, 16'h0000, lat);
        check("bload_latency", 16'(lat), 16'd2);
        check("bload_21", lsu_rd_data_o, 16'h0012);
        do_req(1'b1, 1'b0, 8'h22, 16'h77CC, lat);
        check("store_keeps_rd", lsu_rd_data_o, 16'h0012);
        check("bstore_mem22", 16'(mem[8'h22]), 16'h00CC);

        // Request held high across a whole halfword load.
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 1'b1; lsu_addr_i = 8'h20;
        @(negedge clk);
        nb = 0; nrd = 0; nd = 0; guard = 0;
        while (lsu_busy_o && guard < 10) begin
            nb++;
            if (data_mem_rd_enb_o) nrd++;
            if (lsu_done_o) nd++;
            @(negedge clk);
            guard++;
        end
        check("held_busy_cycles", 16'(nb), 16'd3);
        check("held_rd_cycles", 16'(nrd), 16'd2);
        check("held_done_pulses", 16'(nd), 16'd1);
        check("held_idle_gap", 16'(lsu_busy_o), 16'h0);
        @(negedge clk);
        check("held_reaccept", 16'(lsu_busy_o), 16'h1);
        lsu_req_i = 1'b0;
        guard = 0;
        while (!lsu_done_o && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("held_rd_data", lsu_rd_data_o, 16'h1234);

        // Reset during BYTE0 of a halfword store.
        d0 = n_done;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 1'b1;
        lsu_addr_i = 8'h40; lsu_wr_data_i = 16'h5566;
        @(posedge clk);
        #1;
        check("abort_in_byte0", 16'(data_mem_wr_enb_o), 16'h1);
        #1 rst = 1'b0;
        #1;
        lsu_req_i = 1'b0;
        check("abort_wr_enb", 16'(data_mem_wr_enb_o), 16'h0);
        check("abort_busy", 16'(lsu_busy_o), 16'h0);
        check("abort_rd_cleared", lsu_rd_data_o, 16'h0000);
        repeat (3) @(negedge clk);
        check("abort_no_done", 16'(n_done - d0), 16'd0);
        check("abort_mem40", 16'(mem[8'h40]), 16'h0000);
        check("abort_mem41", 16'(mem[8'h41]), 16'h0000);
        rst = 1'b1;

        do_req(1'b0, 1'b0, 8'h10, 16'h0000, lat);
        check("post_reset_latency", 16'(lat), 16'd2);
        check("post_reset_load", lsu_rd_data_o, 16'h005A);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 8, byte address width; the memory space is 2^ADDR_W bytes.
REQ-002 Parameter: DATA_W, 8, memory byte width; the load/store datum is 2*DATA_W bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 lsu_req_i  input  1  request strobe from core, sampled only while lsu_busy_o=0.
REQ-006 lsu_we_i  input  1  1=store, 0=load.
REQ-007 lsu_size_i  input  1  0=byte, 1=halfword (two bytes, little-endian).
REQ-008 lsu_addr_i  input  ADDR_W  start byte address.
REQ-009 lsu_wr_data_i  input  2*DATA_W  store data; byte 0 = bits [7:0].
REQ-010 lsu_busy_o  output  1  transaction in progress; new requests ignored.
REQ-011 lsu_done_o  output  1  one-cycle completion pulse.
REQ-012 lsu_rd_data_o  output  2*DATA_W  load result.
REQ-013 data_mem_rd_enb_o  output  1  memory read enable.
REQ-014 data_mem_wr_enb_o  output  1  memory write enable (memory writes on the rising edge).
REQ-015 data_mem_addr_o  output  ADDR_W  memory byte address.
REQ-016 data_mem_wr_data_o  output  DATA_W  memory write byte.
REQ-017 data_mem_rd_data_i  input  DATA_W  memory read byte, combinational from address/enable.

Function
REQ-018 FSM states: IDLE, BYTE0, BYTE1, DONE.
REQ-019 IDLE->BYTE0 when lsu_req_i=1 at a rising edge; we, size, addr and wr_data are captured at that edge.
REQ-020 BYTE0->BYTE1 if captured size=1, else BYTE0->DONE.
REQ-021 BYTE1->DONE unconditionally.
REQ-022 DONE->IDLE unconditionally.
REQ-023 lsu_busy_o=1 in BYTE0, BYTE1 and DONE; a lsu_req_i asserted then is dropped, not queued.
REQ-024 lsu_done_o=1 only in DONE. Latency from request edge to done: byte 2 cycles, halfword 3 cycles.
REQ-025 In BYTE0: data_mem_addr_o=captured addr. Load: rd_enb=1, wr_enb=0. Store: wr_enb=1, rd_enb=0, wr_data=byte 0.
REQ-026 In BYTE1: data_mem_addr_o=(captured addr+1) mod 2^ADDR_W, so 8'hFF wraps to 8'h00. Enables as in BYTE0; store wr_data=byte 1.
REQ-027 Outside BYTE0/BYTE1, all data_mem_* outputs SHALL be 0.
REQ-028 Load: data_mem_rd_data_i is registered at the end of BYTE0 into result[7:0] and at the end of BYTE1 into result[15:8].
REQ-029 A byte load zero-extends: result[15:8]=0.
REQ-030 lsu_rd_data_o updates only on load completion, is valid in DONE, and holds until the next load completes; stores leave it unchanged.
REQ-031 Address arithmetic is ADDR_W bits, modular, with no error or flag on wrap.

Reset
REQ-032 On rst=0, asynchronously: state=IDLE, captured request and lsu_rd_data_o cleared to 0, lsu_busy_o=0, lsu_done_o=0, all data_mem_* outputs 0.
REQ-033 Reset mid-transaction aborts it immediately: no further memory write, no done pulse; first request accepted on the first rising edge with rst=1.

Structure
REQ-034 State encodings (IDLE=2'd0, BYTE0=2'd1, BYTE1=2'd2, DONE=2'd3) and size codes (SZ_BYTE=0, SZ_HALF=1) belong in the shared processor defines package.
REQ-035 No sub-module; the FSM, capture registers and address incrementer are a single module instantiated between the core and data_mem.

Verification
REQ-036 Byte store addr=8'h10, wr_data=16'hAB5A -> one cycle with wr_enb=1, addr=8'h10, wr_data=8'h5A; done 2 cycles after request; rd_data unchanged.
REQ-037 Halfword store addr=8'h20, data=16'h1234, then halfword load addr=8'h20 -> mem[20]=34, mem[21]=12; load lsu_rd_data_o=16'h1234 with done 3 cycles after request.
REQ-038 Halfword store addr=8'hFF, data=16'hBEEF -> mem[FF]=EF, mem[00]=BE; load 8'hFF returns 16'hBEEF.
REQ-039 Byte load addr=8'h21 after REQ-037 -> lsu_rd_data_o=16'h0012.
REQ-040 lsu_req_i held high through a halfword load -> exactly one transaction until busy falls, then the next is accepted from IDLE.
REQ-041 rst asserted during BYTE0 of a halfword store to 8'h40 -> wr_enb falls immediately; no done pulse; busy=0; mem[41] stays 0.
